// File: rtl/dm_line_xfer.sv
// Line-transfer sequencer: moves one 4-word cache line between the cache and banked main memory,
// either as a fill (memory to cache) or a dirty writeback (cache to memory).
module dm_line_xfer #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [12:0] req_line,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  cache_offset,
  input  logic [15:0] cache_rd_data,
  output logic        fill_wr,
  output logic [15:0] fill_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_data_wr,
  input  logic [15:0] mem_data_rd,
  input  logic        mem_stall
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  iss_cnt_q, iss_cnt_d;
  logic [12:0] line_q, line_d;
  logic        mode_wr_q, mode_wr_d;

  // Return pipeline: one slot per cycle of read latency; only accepted fill reads carry valid.
  logic [MEM_LAT-1:0] pipe_valid_q, pipe_valid_d;
  logic [1:0]         pipe_word_q [MEM_LAT];
  logic [1:0]         pipe_word_d [MEM_LAT];

  logic       push_valid;
  logic       ret_valid;
  logic [1:0] ret_word;

  assign ret_valid = pipe_valid_q[MEM_LAT-1];
  assign ret_word  = pipe_word_q[MEM_LAT-1];

  always_comb begin
    state_d      = state_q;
    iss_cnt_d    = iss_cnt_q;
    line_d       = line_q;
    mode_wr_d    = mode_wr_q;
    req_ready    = 1'b0;
    busy         = (state_q != StIdle);
    done         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_data_wr  = 16'h0000;
    cache_offset = 3'b000;
    push_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_d    = req_line;
          mode_wr_d = req_wr;
          iss_cnt_d = 2'd0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        mem_addr = {line_q, iss_cnt_q, 1'b0};
        mem_rd   = !mode_wr_q;
        mem_wr   = mode_wr_q;
        if (mode_wr_q) begin
          cache_offset = {iss_cnt_q, 1'b0};
          mem_data_wr  = cache_rd_data;
        end
        // A stalled cycle holds the counter so the identical request is re-presented.
        if (!mem_stall) begin
          iss_cnt_d  = iss_cnt_q + 2'd1;
          push_valid = !mode_wr_q;
          if (iss_cnt_q == 2'd3) begin
            state_d = mode_wr_q ? StDone : StDrain;
          end
        end
      end
      StDrain: begin
        if (ret_valid && (ret_word == 2'd3)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Fill returns overlap later issues and own the cache offset when present.
    fill_wr   = ret_valid;
    fill_data = ret_valid ? mem_data_rd : 16'h0000;
    if (ret_valid) begin
      cache_offset = {ret_word, 1'b0};
    end
  end

  always_comb begin
    pipe_valid_d    = pipe_valid_q;
    pipe_word_d     = pipe_word_q;
    pipe_valid_d[0] = push_valid;
    pipe_word_d[0]  = iss_cnt_q;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_word_d[i]  = pipe_word_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      iss_cnt_q    <= 2'd0;
      line_q       <= 13'h0000;
      mode_wr_q    <= 1'b0;
      pipe_valid_q <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        pipe_word_q[i] <= 2'd0;
      end
    end else begin
      state_q      <= state_d;
      iss_cnt_q    <= iss_cnt_d;
      line_q       <= line_d;
      mode_wr_q    <= mode_wr_d;
      pipe_valid_q <= pipe_valid_d;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        pipe_word_q[i] <= pipe_word_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dm_line_xfer.sv
// Self-checking bench for dm_line_xfer: memory and cache environment models plus a timeline
// reference computed per transfer from the stall pattern.
module tb_dm_line_xfer;

  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [12:0] req_line;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [2:0]  cache_offset;
  logic [15:0] cache_rd_data;
  logic        fill_wr;
  logic [15:0] fill_data;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_data_wr;
  logic [15:0] mem_data_rd;
  logic        mem_stall;

  int compared = 0;
  int mismatched = 0;

  dm_line_xfer #(.MEM_LAT(Lat)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_wr       (req_wr),
    .req_line     (req_line),
    .req_ready    (req_ready),
    .busy         (busy),
    .done         (done),
    .cache_offset (cache_offset),
    .cache_rd_data(cache_rd_data),
    .fill_wr      (fill_wr),
    .fill_data    (fill_data),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_wr  (mem_data_wr),
    .mem_data_rd  (mem_data_rd),
    .mem_stall    (mem_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Cache returns A000 + offset; memory returns mem_word(addr) Lat cycles after acceptance.
  assign cache_rd_data = 16'hA000 + {13'b0, cache_offset};

  bit          env_v [Lat];
  logic [15:0] env_a [Lat];
  always @(posedge clk) begin
    env_v[0] <= mem_rd && !mem_stall;
    env_a[0] <= mem_addr;
    for (int i = 1; i < Lat; i++) begin
      env_v[i] <= env_v[i-1];
      env_a[i] <= env_a[i-1];
    end
  end
  assign mem_data_rd = env_v[Lat-1] ? mem_word(env_a[Lat-1]) : 16'hBEEF;

  // Cycle 0 is the current cycle, in which the request is presented to an idle block.
  task automatic run_xfer(input logic wr, input logic [12:0] line, input logic [63:0] stalls,
                          input logic hold, output int done_at);
    int          acc [4];
    int          c;
    int          w;
    int          last;
    logic        e_iss  [64];
    logic [1:0]  e_word [64];
    logic        e_fill [64];
    logic [2:0]  e_foff [64];
    logic [15:0] e_addr;
    logic [15:0] e_wdat;
    for (int i = 0; i < 64; i++) begin
      e_iss[i]  = 1'b0;
      e_word[i] = 2'd0;
      e_fill[i] = 1'b0;
      e_foff[i] = 3'd0;
    end
    c = 1;
    w = 0;
    while (w < 4) begin
      e_iss[c]  = 1'b1;
      e_word[c] = w[1:0];
      if (!stalls[c]) begin
        acc[w] = c;
        w++;
      end
      c++;
    end
    if (wr) begin
      last = acc[3] + 1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        e_fill[acc[k] + Lat] = 1'b1;
        e_foff[acc[k] + Lat] = {k[1:0], 1'b0};
      end
      last = acc[3] + Lat + 1;
    end
    done_at = -1;
    for (int cy = 0; cy <= last; cy++) begin
      req_valid = (cy == 0) || hold;
      if (cy == 0) begin
        req_wr   = wr;
        req_line = line;
      end
      mem_stall = stalls[cy];
      #4;
      compared++;
      if (req_ready !== (cy == 0) || busy !== (cy != 0)) begin
        mismatched++;
        $display("FAIL handshake cycle %0d: got ready=%b busy=%b want ready=%b busy=%b",
                 cy, req_ready, busy, cy == 0, cy != 0);
      end
      compared++;
      if (done !== (cy == last)) begin
        mismatched++;
        $display("FAIL done cycle %0d: got %b want %b", cy, done, cy == last);
      end
      if (done === 1'b1 && done_at < 0) done_at = cy;
      compared++;
      if (mem_rd !== (e_iss[cy] && !wr) || mem_wr !== (e_iss[cy] && wr)) begin
        mismatched++;
        $display("FAIL strobe cycle %0d: got rd=%b wr=%b want rd=%b wr=%b",
                 cy, mem_rd, mem_wr, e_iss[cy] && !wr, e_iss[cy] && wr);
      end
      if (e_iss[cy]) begin
        e_addr = {line, e_word[cy], 1'b0};
        compared++;
        if (mem_addr !== e_addr) begin
          mismatched++;
          $display("FAIL mem_addr cycle %0d: got %h want %h", cy, mem_addr, e_addr);
        end
        if (wr) begin
          e_wdat = 16'hA000 + {13'b0, e_word[cy], 1'b0};
          compared++;
          if (mem_data_wr !== e_wdat) begin
            mismatched++;
            $display("FAIL mem_data_wr cycle %0d: got %h want %h", cy, mem_data_wr, e_wdat);
          end
        end
      end
      compared++;
      if (fill_wr !== e_fill[cy]) begin
        mismatched++;
        $display("FAIL fill_wr cycle %0d: got %b want %b", cy, fill_wr, e_fill[cy]);
      end
      if (e_fill[cy]) begin
        e_wdat = mem_word({line, e_foff[cy]});
        compared++;
        if (cache_offset !== e_foff[cy] || fill_data !== e_wdat) begin
          mismatched++;
          $display("FAIL fill cycle %0d: got off=%0d data=%h want off=%0d data=%h",
                   cy, cache_offset, fill_data, e_foff[cy], e_wdat);
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = hold;
    mem_stall = 1'($urandom);
    #4;
    compared++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL back_to_idle: got ready=%b busy=%b done=%b want 1 0 0",
               req_ready, busy, done);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wr    = 1'($urandom);
      req_line  = 13'($urandom);
      mem_stall = 1'($urandom);
      #4;
      compared++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 ||
          fill_wr !== 1'b0 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL idle: got ready=%b busy=%b rd=%b wr=%b fill=%b done=%b want 1 0 0 0 0 0",
                 req_ready, busy, mem_rd, mem_wr, fill_wr, done);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    compared++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_rd !== 1'b0 ||
        mem_wr !== 1'b0 || fill_wr !== 1'b0 || mem_addr !== 16'h0 || cache_offset !== 3'd0 ||
        fill_data !== 16'h0 || mem_data_wr !== 16'h0) begin
      mismatched++;
      $display("FAIL %s: got ready=%b busy=%b done=%b rd=%b wr=%b fill=%b addr=%h off=%0d fd=%h wd=%h want 1 0 0 0 0 0 0000 0 0000 0000",
               name, req_ready, busy, done, mem_rd, mem_wr, fill_wr, mem_addr, cache_offset,
               fill_data, mem_data_wr);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_line  = 13'h0;
    mem_stall = 1'b0;
    #3;
    check_reset_values("reset_values");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(10);
  endtask

  task automatic test_fill_basic();
    int d;
    @(posedge clk);
    #1;
    run_xfer(1'b0, 13'h0A5, 64'h0, 1'b0, d);
    compared++;
    if (d !== 7) begin
      mismatched++;
      $display("FAIL fill_done_cycle: got %0d want 7", d);
    end
    idle_cycles(2);
  endtask

  task automatic test_writeback_basic();
    int d;
    @(posedge clk);
    #1;
    run_xfer(1'b1, 13'h1FFF, 64'h0, 1'b0, d);
    compared++;
    if (d !== 5) begin
      mismatched++;
      $display("FAIL wb_done_cycle: got %0d want 5", d);
    end
    idle_cycles(2);
  endtask

  task automatic test_fill_stall();
    int d;
    @(posedge clk);
    #1;
    // Word 1 is first presented in cycle 2 and stalled there for three cycles.
    run_xfer(1'b0, 13'h0A5, 64'h1C, 1'b0, d);
    compared++;
    if (d !== 10) begin
      mismatched++;
      $display("FAIL stall_done_cycle: got %0d want 10", d);
    end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    int d;
    @(posedge clk);
    #1;
    run_xfer(1'b0, 13'h0123, 64'h0, 1'b1, d);
    run_xfer(1'b1, 13'h1ABC, 64'h4, 1'b0, d);
    idle_cycles(2);
  endtask

  task automatic test_random();
    int          d;
    logic        hold;
    logic        wr;
    logic [12:0] line;
    logic [63:0] st;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      wr   = 1'($urandom);
      line = 13'($urandom);
      st   = {40'b0, 24'($urandom & $urandom)};
      hold = (i < 11) && 1'($urandom);
      run_xfer(wr, line, st, hold, d);
      if (!hold) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_fill();
    logic [12:0] line;
    logic [15:0] e_addr;
    line = 13'($urandom);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_line  = line;
    mem_stall = 1'b0;
    for (int cy = 1; cy <= 3; cy++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
    #4;
    e_addr = {line, 2'd2, 1'b0};
    compared++;
    if (mem_rd !== 1'b1 || mem_addr !== e_addr) begin
      mismatched++;
      $display("FAIL mid_fill_issue: got rd=%b addr=%h want 1 %h", mem_rd, mem_addr, e_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #4;
    check_reset_values("reset_mid_fill");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(8);
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_writeback_basic();
    test_fill_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dm_line_xfer.md
Name: dm_line_xfer

Overview:
- Line-transfer sequencer between the direct-mapped cache controller FSM and the four-banked main memory.
- On one request it moves a full 4-word (8-byte) cache line: either a fill (memory to cache) or a dirty writeback (cache to memory).
- Handles per-word memory stall retry and the fixed memory read latency, and returns a single-cycle done pulse to the controller.
- Removes the per-offset memory sequencing states from the cache controller FSM.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from accepted mem_rd to valid mem_data_rd; legal range 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  line transfer request from cache controller
- req_wr  in  1  1 = writeback (cache to memory), 0 = fill (memory to cache)
- req_line  in  13  line address {tag[4:0], index[7:0]} = addr[15:3]
- req_ready  out  1  block idle; request accepted this cycle if req_valid
- busy  out  1  transfer in progress (state != IDLE)
- done  out  1  one-cycle pulse, transfer complete
- cache_offset  out  3  word offset to cache: {word[1:0], 1'b0}
- cache_rd_data  in  16  cache data at cache_offset (writeback source, combinational)
- fill_wr  out  1  write fill_data into cache at cache_offset
- fill_data  out  16  returning memory word
- mem_addr  out  16  {line, word[1:0], 1'b0}
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_data_wr  out  16  memory write data
- mem_data_rd  in  16  memory read data
- mem_stall  in  1  memory rejects this cycle's request

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; iss_cnt = 0; return pipeline valids = 0.
  - req_ready = 1; all other outputs = 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_line and req_wr, clear iss_cnt, go to ISSUE.
  - req_valid is ignored in every other state.
- ISSUE:
  - mem_addr = {line, iss_cnt, 1'b0}.
  - mem_rd = !mode_wr; mem_wr = mode_wr.
  - Writeback: cache_offset = {iss_cnt, 1'b0}; mem_data_wr = cache_rd_data (same cycle).
  - Request accepted when mem_stall = 0: iss_cnt increments (2-bit).
  - On mem_stall = 1: hold iss_cnt and re-present the identical request next cycle.
  - Fill accept: push {valid = 1, word = iss_cnt} into a MEM_LAT-deep return shift pipeline; a stalled cycle pushes valid = 0.
  - On acceptance of word 3: writeback goes to DONE; fill goes to DRAIN.
- Return pipeline:
  - Advances every cycle regardless of state or stall.
  - An entry reaching the output in cycle t+MEM_LAT (accepted at t) drives fill_wr = 1, cache_offset = {word, 1'b0}, fill_data = mem_data_rd.
  - Fill returns overlap subsequent issues; cache_offset is driven by the return entry in fill mode.
- DRAIN:
  - No memory strobes.
  - Go to DONE in the cycle after the word-3 fill_wr.
  - If MEM_LAT returns have already completed, DRAIN still lasts at least one cycle.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - req_ready = 0 during DONE.
- busy = 1 in ISSUE, DRAIN and DONE.
- Words always transfer in order 0,1,2,3, starting from word 0 regardless of the requesting offset.
- Boundary cases:
  - Consecutive stalls of any length are allowed, with no timeout.
  - mem_stall is ignored outside ISSUE.
  - Reset mid-transfer immediately returns to IDLE and clears the return pipeline; in-flight read data is discarded (no fill_wr after reset).
- Latency, no stalls, MEM_LAT = 2, request accepted in cycle 0:
  - Writeback: issues in cycles 1-4, done in cycle 5.
  - Fill: issues in cycles 1-4, fill_wr in cycles 3-6, done in cycle 7.

Test Plan:
- Reset, then idle: req_ready = 1, busy = 0, and all strobes remain 0 for 10 cycles.
- Fill, req_line = 13'h0A5, no stalls, MEM_LAT = 2:
  - mem_rd with mem_addr 0x0528, 0x052A, 0x052C, 0x052E in cycles 1-4.
  - fill_wr with offsets 0, 2, 4, 6 in cycles 3-6, fill_data equal to the memory model words.
  - done pulse in cycle 7.
- Writeback, req_line = 13'h1FFF, cache model returning 16'hA000 + offset:
  - mem_wr at 0xFFF8..0xFFFE with data A000, A002, A004, A006.
  - done pulse in cycle 5.
- Fill with mem_stall high for 3 cycles on word 1:
  - mem_addr held at word 1 for 4 cycles; no duplicate or missing fill_wr.
  - Offsets still 0, 2, 4, 6; done pulse delayed by 3 cycles.
- Reset asserted the cycle after the word-2 issue of a fill: outputs return to reset values immediately, with no fill_wr or done afterwards.
- Second req_valid held high during a busy transfer: ignored, then accepted on the first IDLE cycle after done.
